// File: rtl/pe_axi_mem_slave.sv
// AXI4 slave backed by a word-addressed on-chip memory.
// Independent write and read FSMs; FIXED/INCR bursts, byte strobes, decode errors.
module pe_axi_mem_slave #(
   parameter int unsigned MEM_BYTES = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned RD_WAIT   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] s_awaddr,
   input  logic [7:0]  s_awlen,
   input  logic [2:0]  s_awsize,
   input  logic [1:0]  s_awburst,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wlast,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [31:0] s_araddr,
   input  logic [7:0]  s_arlen,
   input  logic [2:0]  s_arsize,
   input  logic [1:0]  s_arburst,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rlast,
   output logic        s_rvalid,
   input  logic        s_rready
);

   localparam int unsigned NW = MEM_BYTES / 4;
   localparam int unsigned AW = $clog2(NW);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [3:0] WAIT_LAST   = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   logic [31:0] mem [NW];

   // size is ignored: every beat is a full word
   logic unused_size;
   assign unused_size = ^{s_awsize, s_arsize};

   logic [31:0] aw_off, ar_off;
   logic [1:0]  aw_status, ar_status;
   logic [AW-1:0] aw_idx, ar_idx;

   assign aw_off = s_awaddr - BASE_ADDR;
   assign ar_off = s_araddr - BASE_ADDR;
   assign aw_idx = aw_off[AW+1:2];
   assign ar_idx = ar_off[AW+1:2];

   always_comb begin
      aw_status = RESP_OKAY;
      if (aw_off >= MEM_BYTES)  aw_status = RESP_DECERR;
      else if (s_awburst[1])    aw_status = RESP_SLVERR;
      ar_status = RESP_OKAY;
      if (ar_off >= MEM_BYTES)  ar_status = RESP_DECERR;
      else if (s_arburst[1])    ar_status = RESP_SLVERR;
   end

   // ---------------- write channel ----------------
   w_state_t      w_state, w_next;
   logic [AW-1:0] w_idx;
   logic          w_fixed;
   logic [7:0]    w_len;
   logic [8:0]    w_cnt;
   logic [1:0]    w_resp;
   logic          aw_hs, w_hs, b_hs, w_we;

   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid & s_wready;
   assign b_hs  = s_bvalid & s_bready;
   assign w_we  = w_hs && (w_resp == RESP_OKAY) && (w_cnt <= {1'b0, w_len});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs)           w_next = W_DATA;
         W_DATA:  if (w_hs && s_wlast) w_next = W_RESP;
         W_RESP:  if (b_hs)            w_next = W_IDLE;
         default:                      w_next = W_IDLE;
      endcase
   end

   always_comb begin
      s_awready = (w_state == W_IDLE);
      s_wready  = (w_state == W_DATA);
      s_bvalid  = (w_state == W_RESP);
      s_bresp   = s_bvalid ? w_resp : RESP_OKAY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_idx   <= '0;
         w_fixed <= 1'b0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_resp  <= RESP_OKAY;
      end else if (aw_hs) begin
         w_idx   <= aw_idx;
         w_fixed <= (s_awburst == 2'b00);
         w_len   <= s_awlen;
         w_cnt   <= '0;
         w_resp  <= aw_status;
      end else if (w_hs) begin
         if (!w_fixed) w_idx <= w_idx + 1'b1;
         if (w_cnt != '1) w_cnt <= w_cnt + 1'b1;
         // a wlast that does not land on beat awlen flags the whole burst
         if (s_wlast && (w_cnt != {1'b0, w_len}) && (w_resp == RESP_OKAY))
            w_resp <= RESP_SLVERR;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (s_wstrb[b]) mem[w_idx][8*b +: 8] <= s_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   r_state_t      r_state, r_next;
   logic [AW-1:0] r_idx;
   logic [7:0]    r_beat, r_len;
   logic [1:0]    r_resp;
   logic          r_fixed;
   logic [3:0]    wait_cnt;
   logic [31:0]   rdata_q;
   logic [1:0]    rresp_q;
   logic          rlast_q;
   logic          ar_hs, r_hs, r_load, wait_done;

   logic [AW-1:0] ld_idx;
   logic [7:0]    ld_beat, ld_len;
   logic [1:0]    ld_resp;
   logic          ld_fixed;

   assign ar_hs     = s_arvalid & s_arready;
   assign r_hs      = s_rvalid & s_rready;
   assign wait_done = (r_state == R_WAIT) && (wait_cnt == WAIT_LAST);
   assign r_load    = ((r_state == R_IDLE) && ar_hs && (RD_WAIT == 0)) ||
                      wait_done ||
                      ((r_state == R_DATA) && r_hs && !rlast_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)            r_next = (RD_WAIT == 0) ? R_DATA : R_WAIT;
         R_WAIT:  if (wait_done)        r_next = R_DATA;
         R_DATA:  if (r_hs && rlast_q)  r_next = R_IDLE;
         default:                       r_next = R_IDLE;
      endcase
   end

   always_comb begin
      s_arready = (r_state == R_IDLE);
      s_rvalid  = (r_state == R_DATA);
      s_rdata   = rdata_q;
      s_rresp   = rresp_q;
      s_rlast   = rlast_q & s_rvalid;
   end

   // beat 0 loads straight from the AR channel when there is no wait
   always_comb begin
      if (r_state == R_IDLE) begin
         ld_idx   = ar_idx;
         ld_beat  = '0;
         ld_len   = s_arlen;
         ld_resp  = ar_status;
         ld_fixed = (s_arburst == 2'b00);
      end else begin
         ld_idx   = r_idx;
         ld_beat  = r_beat;
         ld_len   = r_len;
         ld_resp  = r_resp;
         ld_fixed = r_fixed;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_beat   <= '0;
         r_len    <= '0;
         r_resp   <= RESP_OKAY;
         r_fixed  <= 1'b0;
         wait_cnt <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         rlast_q  <= 1'b0;
      end else begin
         if ((r_state == R_IDLE) && ar_hs) begin
            r_idx    <= ar_idx;
            r_beat   <= '0;
            r_len    <= s_arlen;
            r_resp   <= ar_status;
            r_fixed  <= (s_arburst == 2'b00);
            wait_cnt <= '0;
         end else if (r_state == R_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (r_load) begin
            rdata_q <= (ld_resp == RESP_OKAY) ? mem[ld_idx] : '0;
            rresp_q <= ld_resp;
            rlast_q <= (ld_beat == ld_len);
            r_idx   <= ld_fixed ? ld_idx : ld_idx + 1'b1;
            r_beat  <= ld_beat + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pe_axi_mem_slave.sv
// Directed self-checking bench for pe_axi_mem_slave (RD_WAIT=0 main instance,
// RD_WAIT=2 second instance for read-latency checks).
module tb_pe_axi_mem_slave;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  wstrb;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;

   logic [31:0] w_araddr, w_rdata;
   logic [7:0]  w_arlen;
   logic [1:0]  w_arburst, w_rresp, w_bresp;
   logic w_arvalid, w_arready, w_rlast, w_rvalid, w_rready;
   logic w_awready, w_wready, w_bvalid;

   pe_axi_mem_slave #(.MEM_BYTES(4096), .BASE_ADDR(32'h0), .RD_WAIT(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(awaddr), .s_awlen(awlen), .s_awsize(awsize), .s_awburst(awburst),
      .s_awvalid(awvalid), .s_awready(awready),
      .s_wdata(wdata), .s_wstrb(wstrb), .s_wlast(wlast), .s_wvalid(wvalid), .s_wready(wready),
      .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
      .s_araddr(araddr), .s_arlen(arlen), .s_arsize(arsize), .s_arburst(arburst),
      .s_arvalid(arvalid), .s_arready(arready),
      .s_rdata(rdata), .s_rresp(rresp), .s_rlast(rlast), .s_rvalid(rvalid), .s_rready(rready)
   );

   pe_axi_mem_slave #(.MEM_BYTES(4096), .BASE_ADDR(32'h0), .RD_WAIT(2)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(32'h0), .s_awlen(8'h0), .s_awsize(3'd2), .s_awburst(2'b01),
      .s_awvalid(1'b0), .s_awready(w_awready),
      .s_wdata(32'h0), .s_wstrb(4'h0), .s_wlast(1'b0), .s_wvalid(1'b0), .s_wready(w_wready),
      .s_bresp(w_bresp), .s_bvalid(w_bvalid), .s_bready(1'b1),
      .s_araddr(w_araddr), .s_arlen(w_arlen), .s_arsize(3'd2), .s_arburst(w_arburst),
      .s_arvalid(w_arvalid), .s_arready(w_arready),
      .s_rdata(w_rdata), .s_rresp(w_rresp), .s_rlast(w_rlast), .s_rvalid(w_rvalid), .s_rready(w_rready)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] wbuf [8];
   logic [31:0] rbuf [16];
   logic [1:0]  rrsp [16];
   logic        rlst [16];

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int nbeats, input logic [3:0] strb, output logic [1:0] resp);
      int t;
      @(negedge clk);
      awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
      t = 0;
      while (!awready && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (!awready || wready !== 1'b0) begin
         failures++; $display("FAIL aw_accept awready=%b wready=%b exp awready=1 wready=0", awready, wready);
      end
      @(negedge clk);
      awvalid = 1'b0;
      checks++;
      if (wready !== 1'b1) begin
         failures++; $display("FAIL wready_after_aw got=%b exp=1", wready);
      end
      for (int i = 0; i < nbeats; i++) begin
         wdata = wbuf[i]; wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
         t = 0;
         while (!wready && t < 50) begin @(negedge clk); t++; end
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++;
      if (bvalid !== 1'b1) begin
         failures++; $display("FAIL bvalid_timing got=%b exp=1", bvalid);
      end
      resp = bresp;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input bit toggle, output int lat);
      int t, cyc, nb;
      bit hold, seen;
      logic [31:0] hdata;
      logic        hlast;
      @(negedge clk);
      araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      arvalid = 1'b0;
      lat = 0; cyc = 0; nb = 0; hold = 0; seen = 0; hdata = '0; hlast = 1'b0;
      while (nb < int'(len) + 1 && cyc < 300) begin
         rready = toggle ? cyc[0] : 1'b1;
         if (rvalid && !seen) begin seen = 1; lat = cyc + 1; end
         if (rvalid && hold) begin
            checks++;
            if (rdata !== hdata || rlast !== hlast) begin
               failures++; $display("FAIL r_stable got=%h/%b exp=%h/%b", rdata, rlast, hdata, hlast);
            end
         end
         if (rvalid && rready) begin
            rbuf[nb] = rdata; rrsp[nb] = rresp; rlst[nb] = rlast; nb++; hold = 0;
         end else if (rvalid) begin
            hold = 1; hdata = rdata; hlast = rlast;
         end
         @(negedge clk);
         cyc++;
      end
      rready = 1'b0;
      checks++;
      if (nb != int'(len) + 1 || rvalid !== 1'b0) begin
         failures++; $display("FAIL r_beat_count got=%0d rvalid_after=%b exp=%0d rvalid_after=0", nb, rvalid, int'(len) + 1);
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000 ||
          bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_values got aw=%b ar=%b w=%b b=%b rv=%b rl=%b bresp=%b rresp=%b rdata=%h exp 1 1 0 0 0 0 00 00 0",
                  awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rdata);
      end
   endtask

   task automatic test_single;
      logic [1:0] resp;
      int lat;
      wbuf[0] = 32'hDEADBEEF;
      do_write(32'h10, 8'd0, 2'b01, 1, 4'hF, resp);
      checks++;
      if (resp !== 2'b00) begin failures++; $display("FAIL single_bresp got=%b exp=00", resp); end
      do_read(32'h10, 8'd0, 2'b01, 1'b0, lat);
      checks++;
      if (rbuf[0] !== 32'hDEADBEEF || rlst[0] !== 1'b1 || rrsp[0] !== 2'b00) begin
         failures++; $display("FAIL single_read got=%h/%b/%b exp=deadbeef/1/00", rbuf[0], rlst[0], rrsp[0]);
      end
      checks++;
      if (lat != 1) begin failures++; $display("FAIL single_rd_latency got=%0d exp=1", lat); end
   endtask

   task automatic test_strobe;
      logic [1:0] resp;
      int lat;
      wbuf[0] = 32'h11223344;
      do_write(32'h20, 8'd0, 2'b01, 1, 4'hF, resp);
      wbuf[0] = 32'h0000AA00;
      do_write(32'h20, 8'd0, 2'b01, 1, 4'h2, resp);
      do_read(32'h20, 8'd0, 2'b01, 1'b0, lat);
      checks++;
      if (rbuf[0] !== 32'h1122AA44) begin failures++; $display("FAIL strobe_merge got=%h exp=1122aa44", rbuf[0]); end
   endtask

   task automatic test_incr_stall;
      logic [1:0] resp;
      int lat;
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      do_write(32'h100, 8'd3, 2'b01, 4, 4'hF, resp);
      checks++;
      if (resp !== 2'b00) begin failures++; $display("FAIL incr_bresp got=%b exp=00", resp); end
      do_read(32'h100, 8'd3, 2'b01, 1'b1, lat);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rbuf[i] !== 32'(i + 1) || rlst[i] !== (i == 3)) begin
            failures++; $display("FAIL incr_beat%0d got=%h/%b exp=%h/%b", i, rbuf[i], rlst[i], i + 1, i == 3);
         end
      end
   endtask

   task automatic test_fixed_decerr;
      logic [1:0] resp;
      int lat;
      wbuf[0] = 32'h5; wbuf[1] = 32'h6; wbuf[2] = 32'h7;
      do_write(32'h40, 8'd2, 2'b00, 3, 4'hF, resp);
      do_read(32'h40, 8'd0, 2'b01, 1'b0, lat);
      checks++;
      if (rbuf[0] !== 32'h7) begin failures++; $display("FAIL fixed_read got=%h exp=7", rbuf[0]); end
      wbuf[0] = 32'hCAFE0000;
      do_write(32'h0, 8'd0, 2'b01, 1, 4'hF, resp);
      wbuf[0] = 32'h55555555;
      do_write(32'h1000, 8'd0, 2'b01, 1, 4'hF, resp);
      checks++;
      if (resp !== 2'b11) begin failures++; $display("FAIL decerr_bresp got=%b exp=11", resp); end
      do_read(32'h0, 8'd0, 2'b01, 1'b0, lat);
      checks++;
      if (rbuf[0] !== 32'hCAFE0000) begin failures++; $display("FAIL decerr_mem_kept got=%h exp=cafe0000", rbuf[0]); end
      do_read(32'h1000, 8'd1, 2'b01, 1'b0, lat);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rbuf[i] !== 32'h0 || rrsp[i] !== 2'b11 || rlst[i] !== (i == 1)) begin
            failures++; $display("FAIL decerr_rbeat%0d got=%h/%b/%b exp=0/11/%b", i, rbuf[i], rrsp[i], rlst[i], i == 1);
         end
      end
   endtask

   task automatic test_burst_err;
      logic [1:0] resp;
      int lat;
      wbuf[0] = 32'h0000600D;
      do_write(32'h60, 8'd0, 2'b01, 1, 4'hF, resp);
      wbuf[0] = 32'hBAD0BAD0;
      do_write(32'h60, 8'd0, 2'b10, 1, 4'hF, resp);
      checks++;
      if (resp !== 2'b10) begin failures++; $display("FAIL wrap_bresp got=%b exp=10", resp); end
      do_read(32'h60, 8'd0, 2'b11, 1'b0, lat);
      checks++;
      if (rbuf[0] !== 32'h0 || rrsp[0] !== 2'b10) begin
         failures++; $display("FAIL rsvd_read got=%h/%b exp=0/10", rbuf[0], rrsp[0]);
      end
      do_read(32'h60, 8'd0, 2'b01, 1'b0, lat);
      checks++;
      if (rbuf[0] !== 32'h0000600D) begin failures++; $display("FAIL wrap_mem_kept got=%h exp=0000600d", rbuf[0]); end
   endtask

   task automatic test_len_mismatch;
      logic [1:0] resp;
      logic [31:0] exp [4];
      int lat;
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hF0 + 32'(i);
      do_write(32'h200, 8'd3, 2'b01, 4, 4'hF, resp);
      wbuf[0] = 32'hA; wbuf[1] = 32'hB;
      do_write(32'h200, 8'd3, 2'b01, 2, 4'hF, resp);
      checks++;
      if (resp !== 2'b10) begin failures++; $display("FAIL short_bresp got=%b exp=10", resp); end
      do_read(32'h200, 8'd3, 2'b01, 1'b0, lat);
      exp = '{32'hA, 32'hB, 32'hF2, 32'hF3};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rbuf[i] !== exp[i]) begin failures++; $display("FAIL short_word%0d got=%h exp=%h", i, rbuf[i], exp[i]); end
      end
      wbuf[0] = 32'hC; wbuf[1] = 32'hD;
      do_write(32'h300, 8'd0, 2'b01, 2, 4'hF, resp);
      checks++;
      if (resp !== 2'b10) begin failures++; $display("FAIL long_bresp got=%b exp=10", resp); end
      do_read(32'h300, 8'd1, 2'b01, 1'b0, lat);
      checks++;
      if (rbuf[0] !== 32'hC || rbuf[1] === 32'hD) begin
         failures++; $display("FAIL long_drop got=%h/%h exp=c/not-d", rbuf[0], rbuf[1]);
      end
   endtask

   task automatic test_rd_wait;
      int t, lat;
      @(negedge clk);
      w_araddr = 32'h10; w_arlen = 8'd0; w_arburst = 2'b01; w_arvalid = 1'b1;
      t = 0;
      while (!w_arready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      w_arvalid = 1'b0;
      lat = 1;
      while (!w_rvalid && lat < 40) begin @(negedge clk); lat++; end
      checks++;
      if (lat != 3 || w_rresp !== 2'b00 || w_rlast !== 1'b1) begin
         failures++; $display("FAIL rd_wait_latency got=%0d/%b/%b exp=3/00/1", lat, w_rresp, w_rlast);
      end
      w_rready = 1'b1;
      @(negedge clk);
      w_rready = 1'b0;
      checks++;
      if (w_rvalid !== 1'b0 || w_arready !== 1'b1) begin
         failures++; $display("FAIL rd_wait_done got rvalid=%b arready=%b exp 0 1", w_rvalid, w_arready);
      end
   endtask

   task automatic test_reset_mid;
      int t, nb, lat;
      @(negedge clk);
      araddr = 32'h100; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      arvalid = 1'b0;
      rready = 1'b1;
      nb = 0; t = 0;
      while (nb < 2 && t < 50) begin
         if (rvalid) nb++;
         @(negedge clk); t++;
      end
      rready = 1'b0;
      checks++;
      if (rvalid !== 1'b1) begin failures++; $display("FAIL mid_read_active got=%b exp=1", rvalid); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0 || arready !== 1'b1) begin
         failures++; $display("FAIL async_reset got rv=%b rl=%b rd=%h ar=%b exp 0 0 0 1", rvalid, rlast, rdata, arready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (arready !== 1'b1) begin failures++; $display("FAIL arready_after_reset got=%b exp=1", arready); end
      do_read(32'h100, 8'd3, 2'b01, 1'b0, lat);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rbuf[i] !== 32'(i + 1) || rlst[i] !== (i == 3)) begin
            failures++; $display("FAIL post_reset_beat%0d got=%h/%b exp=%h/%b", i, rbuf[i], rlst[i], i + 1, i == 3);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
      w_araddr = '0; w_arlen = '0; w_arburst = 2'b01; w_arvalid = 1'b0; w_rready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_strobe();
      test_incr_stall();
      test_fixed_decerr();
      test_burst_err();
      test_len_mismatch();
      test_rd_wait();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
